// File: rtl/approx_arith_pkg.sv
// Shared arithmetic helpers for the exact/approximate arithmetic library:
// segment sizing, borrow type and the single-bit full subtractor.
package approx_arith_pkg;

   typedef logic borrow_t;

   function automatic int seg_w(input int n, input int stages);
      return n / stages;
   endfunction

   // Returns {borrow_out, difference}.
   function automatic logic [1:0] fsub(input logic a, input logic b, input borrow_t bi);
      logic d;
      logic bo;
      d  = a ^ b ^ bi;
      bo = (~a & b) | (~(a ^ b) & bi);
      return {bo, d};
   endfunction

endpackage

// File: rtl/sub_seg.sv
// Combinational W-bit ripple-borrow subtractor segment: d = a - b - bin.
module sub_seg
   import approx_arith_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  borrow_t      bin,
   output logic [W-1:0] d,
   output borrow_t      bout
);

   always_comb begin
      borrow_t    br;
      logic [1:0] r;
      br = bin;
      r  = '0;
      d  = '0;
      for (int i = 0; i < W; i++) begin
         r    = fsub(a[i], b[i], br);
         d[i] = r[0];
         br   = r[1];
      end
      bout = br;
   end

endmodule

// File: rtl/sub12u_pipe.sv
// Exact N-bit unsigned subtractor O = A - B with the borrow chain split into
// STAGES registered segments and valid/ready streaming at one result per cycle.
module sub12u_pipe
   import approx_arith_pkg::*;
#(
   parameter int N      = 12,
   parameter int STAGES = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N:0]   O
);

   localparam int SEG = seg_w(N, STAGES);

   logic [STAGES-1:0] v;
   logic [STAGES-1:0] rdy;
   logic [STAGES-1:0] bor;

   if (N % STAGES != 0) begin : g_bad_cfg
      $error("sub12u_pipe: N must be a multiple of STAGES");
   end

   // A stage may load when it is empty or the stage after it is moving.
   always_comb begin
      logic r;
      r   = out_ready;
      rdy = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         r      = ~v[k] | r;
         rdy[k] = r;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int LO = k * SEG;
      localparam int RW = N - LO;
      localparam int DW = LO + SEG;

      logic [RW-1:0]  src_a;
      logic [RW-1:0]  src_b;
      logic           src_v;
      borrow_t        src_bin;
      logic [SEG-1:0] seg_d;
      borrow_t        seg_bo;
      logic [DW-1:0]  diff_d;
      logic [DW-1:0]  diff_q;
      logic           v_q;
      borrow_t        bor_q;

      if (k == 0) begin : g_head
         assign src_a   = A;
         assign src_b   = B;
         assign src_v   = in_valid;
         assign src_bin = 1'b0;
         assign diff_d  = seg_d;
      end else begin : g_tail
         assign src_a   = g_st[k-1].g_rem.a_rem_q;
         assign src_b   = g_st[k-1].g_rem.b_rem_q;
         assign src_v   = v[k-1];
         assign src_bin = bor[k-1];
         assign diff_d  = {seg_d, g_st[k-1].diff_q};
      end

      sub_seg #(.W(SEG)) u_seg (
         .a    (src_a[SEG-1:0]),
         .b    (src_b[SEG-1:0]),
         .bin  (src_bin),
         .d    (seg_d),
         .bout (seg_bo)
      );

      // ---- stage k register boundary ----
      always_ff @(posedge clk) begin
         if (rst) begin
            v_q    <= 1'b0;
            bor_q  <= 1'b0;
            diff_q <= '0;
         end else if (rdy[k]) begin
            v_q <= src_v;
            if (src_v) begin
               bor_q  <= seg_bo;
               diff_q <= diff_d;
            end
         end
      end

      // Operand bits not yet consumed travel alongside the partial result.
      if (RW > SEG) begin : g_rem
         logic [RW-SEG-1:0] a_rem_q;
         logic [RW-SEG-1:0] b_rem_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               a_rem_q <= '0;
               b_rem_q <= '0;
            end else if (rdy[k] && src_v) begin
               a_rem_q <= src_a[RW-1:SEG];
               b_rem_q <= src_b[RW-1:SEG];
            end
         end
      end

      assign v[k]   = v_q;
      assign bor[k] = bor_q;
   end

   assign in_ready  = rdy[0];
   assign out_valid = v[STAGES-1];
   assign O         = {bor[STAGES-1], g_st[STAGES-1].diff_q};

endmodule
